// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the multi-cycle multiply path: opcodes, special
// register indices, flag bit positions and sequencer state encoding.
package cpu_pkg;

    localparam logic [3:0] OPC_MUL  = 4'hA;
    localparam logic [3:0] OPC_FMUL = 4'hB;

    localparam logic [3:0] REG_SP = 4'd12;
    localparam logic [3:0] REG_LR = 4'd13;

    localparam int FLAG_LOW  = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } mul_state_t;

    // SP and link register writes go through the second register-file port.
    function automatic logic is_link_reg(input logic [3:0] idx);
        return (idx == REG_SP) || (idx == REG_LR);
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Decode/writeback handshake bundle between the decode stage (master) and
// the multiply sequencer (slave).
interface mul_sequencer_if #(parameter int WIDTH = 16);

    logic             start;
    logic             op_fmul;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [3:0]       dest_in;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       dest_sel;
    logic             write_en1;
    logic             write_en2;
    logic [2:0]       flags_out;
    logic             flag_write;

    modport master (
        output start, op_fmul, operand_a, operand_b, dest_in,
        input  busy, stall, done, result, dest_sel,
        input  write_en1, write_en2, flags_out, flag_write
    );

    modport slave (
        input  start, op_fmul, operand_a, operand_b, dest_in,
        output busy, stall, done, result, dest_sel,
        output write_en1, write_en2, flags_out, flag_write
    );

endinterface

// File: rtl/mul_shift_add_core.sv
// Unsigned shift-add multiply datapath: accumulator, multiplicand/multiplier
// shifters and iteration counter. MUL_EARLY_EXIT_EN finishes once the multiplier is exhausted.
module mul_shift_add_core #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH-1:0] acc,
    output logic               finish
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;
    logic               last_iter;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mcand_in};
            mplier <= mplier_in;
            count  <= '0;
        end else if (step) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
        end
    end

    assign last_iter = (count == CNT_W'(WIDTH - 1));

`ifdef MUL_EARLY_EXIT_EN
    // The bits above mplier[0] are what remains after this cycle's shift.
    assign finish = last_iter | (mplier[WIDTH-1:1] == '0);
`else
    assign finish = last_iter;
`endif

endmodule

// File: rtl/mul_sequencer.sv
// MUL/FMUL multi-cycle sequencer: FSM, sign fix-up, result select and
// writeback strobes. MUL_EARLY_EXIT_EN (in the core) shortens runs for small multipliers.
module mul_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic          clk,
    input  logic          reset,
    mul_sequencer_if.slave bus
);

    mul_state_t state, state_nx;

    logic                      load;
    logic                      step;
    logic                      finish;
    logic                      neg_q;
    logic                      fmul_q;
    logic [3:0]                dest_q;
    logic [2*WIDTH-1:0]        acc;
    logic signed [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]          res_w;
    logic [2:0]                flags_w;
    logic                      done_w;
    logic                      link_w;
    logic                      unused_hi;

    // Two's complement magnitude; the most negative value maps to itself,
    // which is still correct when read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .mcand_in  (magnitude($signed(bus.operand_a))),
        .mplier_in (magnitude($signed(bus.operand_b))),
        .acc       (acc),
        .finish    (finish)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            neg_q  <= 1'b0;
            fmul_q <= 1'b0;
            dest_q <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                neg_q  <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
                fmul_q <= bus.op_fmul;
                dest_q <= bus.dest_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (finish)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign product   = neg_q ? -$signed(acc) : $signed(acc);
    assign res_w     = fmul_q ? product[FRAC_BITS+WIDTH-1:FRAC_BITS] : product[WIDTH-1:0];
    assign unused_hi = ^product[2*WIDTH-1:FRAC_BITS+WIDTH];

    always_comb begin
        flags_w            = '0;
        flags_w[FLAG_LOW]  = 1'b0;
        flags_w[FLAG_NEG]  = res_w[WIDTH-1];
        flags_w[FLAG_ZERO] = (res_w == '0);
    end

    assign done_w = (state == DONE);
    assign link_w = is_link_reg(dest_q);

    // Result and flags read as zero outside the writeback cycle.
    assign bus.done       = done_w;
    assign bus.result     = done_w ? res_w : '0;
    assign bus.flags_out  = done_w ? flags_w : 3'b000;
    assign bus.flag_write = done_w;
    assign bus.write_en1  = done_w & ~link_w;
    assign bus.write_en2  = done_w & link_w;
    assign bus.dest_sel   = dest_q;
    assign bus.busy       = (state != IDLE);
    assign bus.stall      = ((state == IDLE) & bus.start) | (state == RUN);

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a result scoreboard; set
// MUL_EARLY_EXIT_EN for both bench and RTL to exercise early exit.
module tb_mul_sequencer;

    localparam int WIDTH     = 16;
    localparam int FRAC_BITS = 8;

    typedef struct {
        logic [15:0] result;
        logic [2:0]  flags;
        logic        we1;
        logic        we2;
        logic [3:0]  dest;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mul_sequencer #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic fmul, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] dest);
        exp_t e;
        logic signed [31:0] p;
        logic [15:0] mag;
        p        = $signed(a) * $signed(b);
        e.result = fmul ? p[23:8] : p[15:0];
        e.flags  = {1'b0, e.result[15], e.result == 16'h0000};
        e.we2    = (dest == 4'd12) || (dest == 4'd13);
        e.we1    = !e.we2;
        e.dest   = dest;
        mag      = b[15] ? (~b + 16'd1) : b;
`ifdef MUL_EARLY_EXIT_EN
        e.lat = 2;
        for (int i = 0; i < 16; i++)
            if (mag[i]) e.lat = 2 + i;
`else
        e.lat = (mag == 16'h0) ? WIDTH + 1 : WIDTH + 1;
`endif
        return e;
    endfunction

    // Issue one operation, track the run cycle by cycle and score the writeback.
    task automatic run_op(input string tag, input logic fmul, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] dest,
                          input logic [15:0] want, input int restart_cyc);
        exp_t e;
        bit seen = 0;
        sb.push_back(model(fmul, a, b, dest));
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.op_fmul   = fmul;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_in   = dest;
        @(negedge clk);
        check({tag, " stall_issue"}, bus.stall, 1);
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(posedge clk); #1;
            bus.operand_a = 16'($urandom);
            bus.operand_b = 16'($urandom);
            bus.dest_in   = 4'($urandom);
            bus.op_fmul   = 1'($urandom);
            bus.start     = (cyc == restart_cyc);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1;
                if (sb.size() == 0) begin
                    check({tag, " sb_empty"}, 0, 1);
                end else begin
                    e = sb.pop_front();
                    check({tag, " latency"},   cyc, e.lat);
                    check({tag, " result"},    bus.result, e.result);
                    check({tag, " result_tp"}, bus.result, want);
                    check({tag, " flags"},     bus.flags_out, e.flags);
                    check({tag, " we1"},       bus.write_en1, e.we1);
                    check({tag, " we2"},       bus.write_en2, e.we2);
                    check({tag, " dest_sel"},  bus.dest_sel, e.dest);
                    check({tag, " flag_wr"},   bus.flag_write, 1);
                    check({tag, " stall_done"}, bus.stall, 0);
                    check({tag, " busy_done"}, bus.busy, 1);
                end
            end else begin
                check({tag, " stall_run"}, bus.stall, 1);
                check({tag, " busy_run"},  bus.busy, 1);
                check({tag, " strobes_run"},
                      {bus.write_en1, bus.write_en2, bus.flag_write}, 3'b000);
            end
        end
        if (!seen) begin
            check({tag, " done_timeout"}, 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, " idle_after"}, {bus.done, bus.busy, bus.stall}, 3'b000);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op_fmul   = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy",   bus.busy, 0);
        check("rst stall",  bus.stall, 0);
        check("rst done",   bus.done, 0);
        check("rst result", bus.result, 0);
        check("rst dest",   bus.dest_sel, 0);
        check("rst flags",  bus.flags_out, 0);
        check("rst strobe", {bus.write_en1, bus.write_en2, bus.flag_write}, 3'b000);
        reset = 1'b0;

        run_op("mul3x5",    1'b0, 16'h0003, 16'h0005, 4'd2,  16'h000F, 0);
        run_op("mulneg",    1'b0, 16'hFFFF, 16'h0003, 4'd1,  16'hFFFD, 0);
        run_op("fmul1.5x2", 1'b1, 16'h0180, 16'h0200, 4'd4,  16'h0300, 0);
        run_op("fmulm1x2.5",1'b1, 16'hFF00, 16'h0280, 4'd5,  16'hFD80, 0);
        run_op("mulz_d13",  1'b0, 16'h0000, 16'h1234, 4'd13, 16'h0000, 0);
        run_op("restart",   1'b0, 16'h0003, 16'h4001, 4'd12, 16'hC003, 5);
        run_op("mulmin",    1'b0, 16'h8000, 16'h8000, 4'd7,  16'h0000, 0);
        run_op("fmulmin",   1'b1, 16'h8000, 16'h0100, 4'd3,  16'h8000, 0);

        // Reset in the middle of a run: nothing may be written back.
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.operand_a = 16'h1234;
        bus.operand_b = 16'h5678;
        bus.dest_in   = 4'd6;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst busy",  bus.busy, 0);
        check("midrst stall", bus.stall, 0);
        check("midrst done",  bus.done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            check("midrst quiet", {bus.done, bus.write_en1, bus.write_en2, bus.flag_write}, 4'b0000);
        end

        run_op("after_rst", 1'b0, 16'h0010, 16'h0010, 4'd1, 16'h0100, 0);

`ifdef MUL_EARLY_EXIT_EN
        run_op("ee_b1",    1'b0, 16'h0007, 16'h0001, 4'd3, 16'h0007, 0);
        run_op("ee_b8000", 1'b0, 16'h0001, 16'h8000, 4'd3, 16'h8000, 0);
        run_op("ee_b0",    1'b0, 16'h0005, 16'h0000, 4'd3, 16'h0000, 0);
`endif

        check("sb drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
